// File: rtl/mat_window_bank.sv
// Neighbourhood register bank for the Mat pipeline: one reference pixel plus N_SEL
// neighbours, scanned one per cycle against a programmable threshold.
module mat_window_bank #(
  parameter int PIX_W   = 8,
  parameter int N_SEL   = 26,
  parameter int ADDR_W  = 5,
  parameter int THR_RST = 30,
  parameter int CNT_W   = $clog2(N_SEL + 1)
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              thr_wr,
  input  logic [PIX_W-1:0]  thr_data,
  input  logic              clear,
  input  logic              start,
  output logic [PIX_W-1:0]  threshold,
  output logic [PIX_W-1:0]  ref_pixel,
  output logic              all_loaded,
  output logic              busy,
  output logic              done,
  output logic [N_SEL-1:0]  match_mask,
  output logic [CNT_W-1:0]  match_count,
  output logic              wr_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } stateT;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SEL);

  stateT              stateReg, stateNext;
  logic [ADDR_W-1:0]  idxReg;
  logic [PIX_W-1:0]   thrReg, thrSnapReg;
  logic [PIX_W-1:0]   pixReg [0:N_SEL];
  logic [N_SEL:0]     loadedReg;
  logic [N_SEL-1:0]   maskReg, maskNext;
  logic [CNT_W-1:0]   countReg;
  logic               wrErrReg;

  logic               addrInRange, wrAccept, wrReject, startAccept, lastIdx;
  logic [PIX_W-1:0]   selPix;
  logic [PIX_W:0]     selExt, refExt, absDiff;
  logic               isMatch;

  assign addrInRange = (wr_addr <= LAST_IDX);
  assign all_loaded  = &loadedReg;
  // clear outranks writes: a dropped write under clear is not an error
  assign wrAccept    = wr_en && !clear && (stateReg == IDLE) && addrInRange;
  assign wrReject    = wr_en && !clear && ((stateReg != IDLE) || !addrInRange);
  assign startAccept = (stateReg == IDLE) && start && all_loaded && !clear;
  assign lastIdx     = (idxReg == LAST_IDX);

  // Unsigned magnitude with one extra bit so the subtraction never wraps
  assign selPix  = pixReg[idxReg];
  assign selExt  = {1'b0, selPix};
  assign refExt  = {1'b0, pixReg[0]};
  assign absDiff = (selExt >= refExt) ? (selExt - refExt) : (refExt - selExt);
  assign isMatch = (absDiff <= {1'b0, thrSnapReg});

  genvar gi;
  generate
    for (gi = 0; gi < N_SEL; gi++) begin : gen_mask
      assign maskNext[gi] = maskReg[gi] | (isMatch && (idxReg == ADDR_W'(gi + 1)));
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state logic
  always_comb begin
    stateNext = stateReg;
    if (clear) begin
      stateNext = IDLE;
    end else begin
      case (stateReg)
        IDLE:    if (startAccept) stateNext = SCAN;
        SCAN:    if (lastIdx) stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (stateReg)
      SCAN:    busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Pixel storage and loaded bitmap
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      for (int i = 0; i <= N_SEL; i++) begin
        pixReg[i] <= '0;
      end
      loadedReg <= '0;
    end else if (clear) begin
      loadedReg <= '0;
    end else if (wrAccept) begin
      pixReg[wr_addr]    <= wr_data;
      loadedReg[wr_addr] <= 1'b1;
    end
  end

  // Threshold, scan datapath and error pulse
  always_ff @(posedge clk) begin
    if (!nRESET) begin
      thrReg     <= PIX_W'(THR_RST);
      thrSnapReg <= '0;
      idxReg     <= ADDR_W'(1);
      maskReg    <= '0;
      countReg   <= '0;
      wrErrReg   <= 1'b0;
    end else begin
      wrErrReg <= wrReject;
      if (thr_wr) begin
        thrReg <= thr_data;
      end
      if (clear) begin
        idxReg   <= ADDR_W'(1);
        maskReg  <= '0;
        countReg <= '0;
      end else if (startAccept) begin
        idxReg     <= ADDR_W'(1);
        thrSnapReg <= thrReg;
        maskReg    <= '0;
        countReg   <= '0;
      end else if (stateReg == SCAN) begin
        maskReg <= maskNext;
        if (isMatch) begin
          countReg <= countReg + CNT_W'(1);
        end
        idxReg <= idxReg + ADDR_W'(1);
      end
    end
  end

  assign threshold   = thrReg;
  assign ref_pixel   = pixReg[0];
  assign match_mask  = maskReg;
  assign match_count = countReg;
  assign wr_err      = wrErrReg;

endmodule

// File: tb/tb_mat_window_bank.sv
// Directed plus randomized bench for mat_window_bank; expected results come from a
// plain-arithmetic model of the neighbourhood match rule.
module tb_mat_window_bank;
  localparam int PIX_W   = 8;
  localparam int N_SEL   = 26;
  localparam int ADDR_W  = 5;
  localparam int THR_RST = 30;
  localparam int CNT_W   = 5;

  logic              clk = 1'b0;
  logic              nRESET = 1'b0;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [PIX_W-1:0]  wr_data = '0;
  logic              thr_wr = 1'b0;
  logic [PIX_W-1:0]  thr_data = '0;
  logic              clear = 1'b0;
  logic              start = 1'b0;
  logic [PIX_W-1:0]  threshold;
  logic [PIX_W-1:0]  ref_pixel;
  logic              all_loaded;
  logic              busy;
  logic              done;
  logic [N_SEL-1:0]  match_mask;
  logic [CNT_W-1:0]  match_count;
  logic              wr_err;

  int tests = 0;
  int fails = 0;

  int mRef;
  int mNbr [1:N_SEL];
  int mThr;

  mat_window_bank #(
    .PIX_W(PIX_W), .N_SEL(N_SEL), .ADDR_W(ADDR_W), .THR_RST(THR_RST), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .nRESET(nRESET), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .thr_wr(thr_wr), .thr_data(thr_data), .clear(clear), .start(start),
    .threshold(threshold), .ref_pixel(ref_pixel), .all_loaded(all_loaded),
    .busy(busy), .done(done), .match_mask(match_mask), .match_count(match_count),
    .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_SEL-1:0] modelMask(input int r, input int t);
    logic [N_SEL-1:0] m;
    m = '0;
    for (int k = 1; k <= N_SEL; k++) begin
      int d;
      d = mNbr[k] - r;
      if (d < 0) d = -d;
      if (d <= t) m[k-1] = 1'b1;
    end
    return m;
  endfunction

  task automatic writePix(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = PIX_W'(data);
    tick();
    wr_en = 1'b0;
    if (addr == 0) mRef = data;
    else if (addr <= N_SEL) mNbr[addr] = data;
    check("wr_err_idle", wr_err, (addr > N_SEL) ? 64'd1 : 64'd0);
  endtask

  task automatic setThr(input int v);
    thr_wr   = 1'b1;
    thr_data = PIX_W'(v);
    tick();
    thr_wr = 1'b0;
    mThr   = v;
    check("thr_write", threshold, v);
  endtask

  task automatic loadModel(input int upto);
    for (int a = 0; a <= upto; a++) begin
      writePix(a, (a == 0) ? mRef : mNbr[a]);
    end
  endtask

  // midAct: 0 none, 1 threshold write mid-scan, 2 pixel write mid-scan
  task automatic runScan(input int midAct);
    logic [N_SEL-1:0] expMask;
    int lat;
    int busyBad;
    expMask = modelMask(mRef, mThr);
    start = 1'b1;
    tick();
    start   = 1'b0;
    lat     = 1;
    busyBad = 0;
    while (done !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1) busyBad++;
      if (lat == 5 && midAct == 1) begin
        thr_wr = 1'b1;
        thr_data = 8'hFF;
      end
      if (lat == 2 && midAct == 2) begin
        wr_en = 1'b1;
        wr_addr = ADDR_W'(1);
        wr_data = PIX_W'(mNbr[1] ^ 8'hA5);
      end
      tick();
      thr_wr = 1'b0;
      wr_en  = 1'b0;
      if (lat == 5 && midAct == 1) begin
        mThr = 255;
        check("thr_mid_scan", threshold, 8'hFF);
      end
      if (lat == 2 && midAct == 2) check("wr_err_busy", wr_err, 1);
      lat++;
    end
    check("done_latency", lat, N_SEL + 1);
    check("busy_during_scan", busyBad, 0);
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    check("mask", match_mask, expMask);
    check("count", match_count, $countones(expMask));
    $display("[TB] scan ref=%0d thr_snap mask=%07h count=%0d lat=%0d", mRef, match_mask, match_count, lat);
    tick();
    check("done_one_cycle", done, 0);
    check("mask_held", match_mask, expMask);
  endtask

  initial begin
    // Reset state
    mRef = 0;
    mThr = THR_RST;
    for (int k = 1; k <= N_SEL; k++) mNbr[k] = 0;
    tick();
    tick();
    nRESET = 1'b1;
    tick();
    check("rst_threshold", threshold, THR_RST);
    check("rst_all_loaded", all_loaded, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_count", match_count, 0);
    check("rst_mask", match_mask, 0);
    check("rst_wr_err", wr_err, 0);

    // Ramp pattern, default threshold
    mRef = 100;
    for (int k = 1; k <= N_SEL; k++) mNbr[k] = 60 + 4 * k;
    loadModel(N_SEL);
    check("loaded_all", all_loaded, 1);
    check("ref_pixel", ref_pixel, 100);
    runScan(0);
    check("ramp_count", match_count, 15);
    check("ramp_mask", match_mask, 26'h001FFFC);

    // Zero threshold: exact matches only
    setThr(0);
    runScan(0);
    check("thr0_count", match_count, 1);
    check("thr0_mask", match_mask, 26'h0000200);

    // Threshold write mid-scan affects only the next scan
    setThr(30);
    runScan(1);
    check("midthr_count", match_count, 15);
    runScan(0);
    check("thr255_count", match_count, 26);

    // Pixel write during a scan is rejected
    runScan(2);

    // Randomized patterns
    for (int it = 0; it < 4; it++) begin
      mRef = $urandom_range(0, 255);
      for (int k = 1; k <= N_SEL; k++) mNbr[k] = $urandom_range(0, 255);
      setThr($urandom_range(0, 255));
      loadModel(N_SEL);
      runScan(0);
    end

    // Extremes of the difference range
    setThr(255);
    writePix(0, 0);
    writePix(1, 255);
    runScan(0);
    check("edge_255_match", match_mask[0], 1);
    setThr(254);
    writePix(0, 255);
    writePix(1, 0);
    runScan(0);
    check("edge_254_nomatch", match_mask[0], 0);

    // Out-of-range addresses
    writePix(27, 8'h77);
    check("bad_addr_loaded", all_loaded, 1);
    tick();
    check("wr_err_one_cycle", wr_err, 0);
    writePix(31, 8'h11);
    check("bad_addr_ref", ref_pixel, mRef);

    // clear, then partial load: start must be ignored
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_loaded", all_loaded, 0);
    check("clr_mask", match_mask, 0);
    check("clr_count", match_count, 0);
    check("clr_keeps_ref", ref_pixel, mRef);
    check("clr_keeps_thr", threshold, 254);
    mRef = 100;
    setThr(30);
    for (int k = 1; k <= N_SEL; k++) mNbr[k] = 60 + 4 * k;
    loadModel(N_SEL - 1);
    check("partial_loaded", all_loaded, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("partial_start_busy", busy, 0);
    check("partial_start_err", wr_err, 0);
    tick();
    check("partial_start_done", done, 0);

    // clear mid-scan aborts without done
    writePix(N_SEL, mNbr[N_SEL]);
    check("full_loaded", all_loaded, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_loaded", all_loaded, 0);
    check("abort_mask", match_mask, 0);
    begin
      int sawDone;
      sawDone = 0;
      for (int c = 0; c < 30; c++) begin
        tick();
        if (done === 1'b1 || busy === 1'b1) sawDone++;
      end
      check("abort_no_done", sawDone, 0);
    end

    // clear and write together: write dropped, no error
    clear = 1'b1;
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = 8'h3C;
    tick();
    clear = 1'b0;
    wr_en = 1'b0;
    check("clrwr_err", wr_err, 0);
    check("clrwr_ref", ref_pixel, mRef);

    // Reset mid-scan
    loadModel(N_SEL);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    nRESET = 1'b0;
    wr_en = 1'b1;
    wr_addr = '0;
    wr_data = 8'h99;
    tick();
    nRESET = 1'b1;
    wr_en = 1'b0;
    check("mrst_threshold", threshold, THR_RST);
    check("mrst_ref", ref_pixel, 0);
    check("mrst_busy", busy, 0);
    check("mrst_done", done, 0);
    check("mrst_loaded", all_loaded, 0);
    check("mrst_mask", match_mask, 0);
    check("mrst_count", match_count, 0);
    check("mrst_wr_err", wr_err, 0);
    tick();
    check("mrst_done_after", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mat_window_bank.md
Name: mat_window_bank

Overview:
- Parametrised neighbourhood register bank for the matching (Mat) pipeline. Holds one reference pixel and N_SEL neighbour pixels, each loaded by address.
- Has a programmable threshold instead of a fixed constant.
- On a start request, a sequential scan compares every neighbour against the reference. It reports a per-neighbour match mask and a match count.
- Sits between the pixel fetch logic, which drives the address/data writes, and the downstream decision logic, which consumes done, mask and count.

Parameters:
- PIX_W, 8: pixel and threshold width in bits.
- N_SEL, 26: number of neighbour pixels, range 1..2^ADDR_W-1.
- ADDR_W, 5: write address width.
- THR_RST, 30: threshold value after reset.
- CNT_W, derived, ceil(log2(N_SEL+1)): match count width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- nRESET  in  1  synchronous, active-low reset; sampled on rising clk.
- wr_en  in  1  pixel write strobe.
- wr_addr  in  ADDR_W  0 = reference pixel; 1..N_SEL = neighbour k.
- wr_data  in  PIX_W  pixel value.
- thr_wr  in  1  threshold write strobe.
- thr_data  in  PIX_W  new threshold.
- clear  in  1  clears loaded flags and aborts any scan.
- start  in  1  request scan (single-cycle pulse or level; level is sampled).
- threshold  out  PIX_W  current threshold register.
- ref_pixel  out  PIX_W  reference register.
- all_loaded  out  1  reference and all N_SEL neighbours written since reset/clear.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when results are valid.
- match_mask  out  N_SEL  bit k-1 = neighbour k matched.
- match_count  out  CNT_W  popcount of match_mask.
- wr_err  out  1  one-cycle pulse on a rejected write.

Behaviour:
- Reset (nRESET=0 at a clk edge):
  - All pixel registers = 0; threshold = THR_RST.
  - Loaded bitmap (N_SEL+1 bits) = 0.
  - State = IDLE.
  - busy = done = wr_err = 0; match_mask = 0; match_count = 0.
  - Reset wins over every other input.
- Pixel write, accepted only when state = IDLE:
  - wr_en=1 with wr_addr <= N_SEL: register updated at the clk edge and its loaded bit set. Visible the next cycle.
  - wr_addr > N_SEL: no register change; wr_err=1 the next cycle.
  - wr_en=1 while state != IDLE: ignored; wr_err=1 the next cycle.
- all_loaded = AND of the loaded bitmap (combinational from registers).
- Threshold write:
  - thr_wr=1 updates threshold in any state.
  - A scan uses a snapshot taken at start acceptance, so a mid-scan write affects only the next scan.
- FSM states: IDLE, SCAN, DONE.
  - IDLE -> SCAN: start=1 and all_loaded=1 and clear=0.
    - idx <= 1; thr_snap <= threshold; mask/count accumulators <= 0.
    - start with all_loaded=0 is ignored, with no error.
  - SCAN:
    - Each cycle compares neighbour idx: match = |sel[idx] - ref| <= thr_snap.
    - The difference is computed at PIX_W+1 bits, unsigned magnitude, so there is no wrap. Equality counts as a match.
    - Set mask bit idx-1 and increment count on a match; idx++.
    - After idx = N_SEL, go to DONE.
    - busy=1 throughout SCAN.
  - DONE: for one cycle, match_mask/match_count present final values and done=1; then go to IDLE.
  - Outputs hold their values until the next accepted start, or until clear/reset zeroes them.
- Latency: start accepted at edge T -> busy during cycles T+1..T+N_SEL -> done at cycle T+N_SEL+1.
- clear=1 (non-reset):
  - Loaded bitmap = 0; state = IDLE; busy = 0.
  - match_mask and match_count = 0; no done pulse.
  - Pixel and threshold registers retain their values.
  - clear and wr_en in the same cycle: clear wins, the write is dropped, no wr_err.
- start in the DONE state or during SCAN: ignored.
- A new start is possible in the cycle after done.
- Pixels are not gated by any read enable. Outputs are always driven, with no X values.

Test Plan:
- Reset, then read outputs -> threshold=30, all_loaded=0, busy=0, done=0, match_count=0.
- Load ref=100, neighbours k=1..26 with value 60+4k (64..164); start -> done exactly 27 cycles after the start edge. Matches are values 70..128 where |v-100|<=30, i.e. k=3..17. Expect match_count=15 and match_mask=0x001FFFC.
- Same data, thr_wr=0 before start -> only an exact 100 matches (k=10); match_count=1, mask bit 9 set.
- thr_wr=255 issued mid-scan with thr=30 -> the current result is unchanged (count 15); the next scan gives count 26.
- Boundary cases:
  - ref=0, neighbour=255, thr=255 -> match.
  - ref=255, neighbour=0, thr=254 -> no match.
  - wr_addr=27 -> wr_err pulse, all_loaded unchanged.
- Mid-operation events:
  - Load all but neighbour 26; start -> ignored, busy stays 0.
  - Load neighbour 26; start; assert clear at cycle T+5 -> busy=0 the next cycle, no done, all_loaded=0, mask=0.
  - nRESET=0 mid-scan -> full reset values.
